// File: rtl/layer_compositor.sv
// -----------------------------------------------------------------------------
// layer_compositor
//   Three-stage pixel compositor. Picks the highest-priority visible layer
//   (index 0 = highest) for each pixel. Visibility depends on the layer's
//   on flag, a per-layer game-state mask, colour-key transparency and a
//   frame-based blink effect. If no layer qualifies, the background colour
//   is used. The VGA syncs and video_on are delayed to stay aligned with
//   the selected pixel, so the outputs can drive the DAC directly.
//
// Ports:
//   clk               pixel-domain clock
//   reset             synchronous, active-low reset
//   ce                pipeline advance enable (pixel tick)
//   video_on          active-video flag from the sync generator
//   hsync_in/vsync_in sync inputs (active low)
//   game_state        one-hot game state
//   layer_on          per-layer pixel-on flags
//   layer_rgb         layer i colour in bits [i*RGB_W +: RGB_W]
//   layer_state_mask  layer i may show in states [i*STATE_W +: STATE_W]
//   blink_mask        layers subject to blinking
//   bg_rgb            background colour
//   rgb               registered pixel to the DAC
//   hsync/vsync       syncs aligned with rgb
//   video_on_out      video_on aligned with rgb
//   hit_valid/hit_idx winning layer flag and index (index 0 when no hit)
//   blink_phase       1 = blinking layers currently visible
// -----------------------------------------------------------------------------
module layer_compositor #(
  parameter int                    NUM_LAYERS   = 12,
  parameter int                    RGB_W        = 12,
  parameter int                    STATE_W      = 3,
  parameter logic [RGB_W-1:0]      KEY_COLOR    = 12'hF0F,
  parameter logic [NUM_LAYERS-1:0] KEY_EN       = {NUM_LAYERS{1'b1}},
  parameter int                    BLINK_FRAMES = 16,
  parameter int                    IDX_W        = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ce,
  input  logic                          video_on,
  input  logic                          hsync_in,
  input  logic                          vsync_in,
  input  logic [STATE_W-1:0]            game_state,
  input  logic [NUM_LAYERS-1:0]         layer_on,
  input  logic [NUM_LAYERS*RGB_W-1:0]   layer_rgb,
  input  logic [NUM_LAYERS*STATE_W-1:0] layer_state_mask,
  input  logic [NUM_LAYERS-1:0]         blink_mask,
  input  logic [RGB_W-1:0]              bg_rgb,
  output logic [RGB_W-1:0]              rgb,
  output logic                          hsync,
  output logic                          vsync,
  output logic                          video_on_out,
  output logic                          hit_valid,
  output logic [IDX_W-1:0]              hit_idx,
  output logic                          blink_phase
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  // ---------------------------------------------------------------------------
  // Blink engine: counts vsync falling edges seen on ce cycles.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] frame_cnt_reg;
  logic             blink_phase_reg;
  logic             vsync_prev_reg;
  logic             vsync_fall;

  assign vsync_fall = vsync_prev_reg & ~vsync_in;

  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_cnt_reg   <= '0;
      blink_phase_reg <= 1'b1;
      vsync_prev_reg  <= 1'b1;
    end else if (ce) begin
      vsync_prev_reg <= vsync_in;
      if (vsync_fall) begin
        if (frame_cnt_reg == CNT_LAST) begin
          frame_cnt_reg   <= '0;
          blink_phase_reg <= ~blink_phase_reg;
        end else begin
          frame_cnt_reg <= frame_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign blink_phase = blink_phase_reg;

  // ---------------------------------------------------------------------------
  // S1: per-layer qualification
  // ---------------------------------------------------------------------------
  logic [NUM_LAYERS-1:0] qual_next;

  generate
    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_qual
      logic [RGB_W-1:0] pix;
      logic             state_ok;
      logic             keyed;
      assign pix      = layer_rgb[gi*RGB_W +: RGB_W];
      assign state_ok = |(layer_state_mask[gi*STATE_W +: STATE_W] & game_state);
      assign keyed    = KEY_EN[gi] & (pix == KEY_COLOR);
      assign qual_next[gi] = layer_on[gi] & state_ok & ~keyed &
                             (~blink_mask[gi] | blink_phase_reg);
    end
  endgenerate

  logic [NUM_LAYERS-1:0]       s1_qual_reg;
  logic [NUM_LAYERS*RGB_W-1:0] s1_rgb_reg;
  logic [RGB_W-1:0]            s1_bg_reg;
  logic                        s1_video_reg;
  logic                        s1_hsync_reg;
  logic                        s1_vsync_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_qual_reg  <= '0;
      s1_rgb_reg   <= '0;
      s1_bg_reg    <= '0;
      s1_video_reg <= 1'b0;
      s1_hsync_reg <= 1'b1;
      s1_vsync_reg <= 1'b1;
    end else if (ce) begin
      s1_qual_reg  <= qual_next;
      s1_rgb_reg   <= layer_rgb;
      s1_bg_reg    <= bg_rgb;
      s1_video_reg <= video_on;
      s1_hsync_reg <= hsync_in;
      s1_vsync_reg <= vsync_in;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: priority select. Scanning from the highest index downwards lets the
  // lowest qualifying index overwrite the others, so it wins.
  // ---------------------------------------------------------------------------
  logic [RGB_W-1:0] sel_rgb_next;
  logic             sel_hit_next;
  logic [IDX_W-1:0] sel_idx_next;

  always_comb begin
    sel_rgb_next = s1_bg_reg;
    sel_hit_next = 1'b0;
    sel_idx_next = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (s1_qual_reg[i]) begin
        sel_rgb_next = s1_rgb_reg[i*RGB_W +: RGB_W];
        sel_hit_next = 1'b1;
        sel_idx_next = IDX_W'(i);
      end
    end
  end

  logic [RGB_W-1:0] s2_rgb_reg;
  logic             s2_hit_reg;
  logic [IDX_W-1:0] s2_idx_reg;
  logic             s2_video_reg;
  logic             s2_hsync_reg;
  logic             s2_vsync_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s2_rgb_reg   <= '0;
      s2_hit_reg   <= 1'b0;
      s2_idx_reg   <= '0;
      s2_video_reg <= 1'b0;
      s2_hsync_reg <= 1'b1;
      s2_vsync_reg <= 1'b1;
    end else if (ce) begin
      s2_rgb_reg   <= sel_rgb_next;
      s2_hit_reg   <= sel_hit_next;
      s2_idx_reg   <= sel_idx_next;
      s2_video_reg <= s1_video_reg;
      s2_hsync_reg <= s1_hsync_reg;
      s2_vsync_reg <= s1_vsync_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // S3: output register with blanking applied
  // ---------------------------------------------------------------------------
  logic             s3_hit_next;
  logic [RGB_W-1:0] s3_rgb_reg;
  logic             s3_hit_reg;
  logic [IDX_W-1:0] s3_idx_reg;
  logic             s3_video_reg;
  logic             s3_hsync_reg;
  logic             s3_vsync_reg;

  assign s3_hit_next = s2_hit_reg & s2_video_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s3_rgb_reg   <= '0;
      s3_hit_reg   <= 1'b0;
      s3_idx_reg   <= '0;
      s3_video_reg <= 1'b0;
      s3_hsync_reg <= 1'b1;
      s3_vsync_reg <= 1'b1;
    end else if (ce) begin
      s3_rgb_reg   <= s2_video_reg ? s2_rgb_reg : '0;
      s3_hit_reg   <= s3_hit_next;
      s3_idx_reg   <= s3_hit_next ? s2_idx_reg : '0;
      s3_video_reg <= s2_video_reg;
      s3_hsync_reg <= s2_hsync_reg;
      s3_vsync_reg <= s2_vsync_reg;
    end
  end

  assign rgb          = s3_rgb_reg;
  assign hit_valid    = s3_hit_reg;
  assign hit_idx      = s3_idx_reg;
  assign video_on_out = s3_video_reg;
  assign hsync        = s3_hsync_reg;
  assign vsync        = s3_vsync_reg;

endmodule

// File: tb/tb_layer_compositor.sv
// -----------------------------------------------------------------------------
// tb_layer_compositor
//   Directed scoreboard bench for layer_compositor. Each issued pixel pushes
//   its hand-computed expected output; a monitor pops one entry per ce edge
//   and compares. Blink phase and reset state are checked directly.
// -----------------------------------------------------------------------------
module tb_layer_compositor;

  localparam int NL = 12;
  localparam int RW = 12;
  localparam int SW = 3;
  localparam int IW = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              ce = 1'b0;
  logic              video_on = 1'b0;
  logic              hsync_in = 1'b1;
  logic              vsync_in = 1'b1;
  logic [SW-1:0]     game_state = 3'b010;
  logic [NL-1:0]     layer_on = '0;
  logic [NL*RW-1:0]  layer_rgb = '0;
  logic [NL*SW-1:0]  layer_state_mask = {NL{3'b111}};
  logic [NL-1:0]     blink_mask = '0;
  logic [RW-1:0]     bg_rgb = 12'h555;
  logic [RW-1:0]     rgb;
  logic              hsync;
  logic              vsync;
  logic              video_on_out;
  logic              hit_valid;
  logic [IW-1:0]     hit_idx;
  logic              blink_phase;

  layer_compositor #(
    .NUM_LAYERS   (NL),
    .RGB_W        (RW),
    .STATE_W      (SW),
    .KEY_COLOR    (12'hF0F),
    .KEY_EN       (12'hFDF),
    .BLINK_FRAMES (2),
    .IDX_W        (IW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .ce               (ce),
    .video_on         (video_on),
    .hsync_in         (hsync_in),
    .vsync_in         (vsync_in),
    .game_state       (game_state),
    .layer_on         (layer_on),
    .layer_rgb        (layer_rgb),
    .layer_state_mask (layer_state_mask),
    .blink_mask       (blink_mask),
    .bg_rgb           (bg_rgb),
    .rgb              (rgb),
    .hsync            (hsync),
    .vsync            (vsync),
    .video_on_out     (video_on_out),
    .hit_valid        (hit_valid),
    .hit_idx          (hit_idx),
    .blink_phase      (blink_phase)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]   id;
    logic [RW-1:0] rgb;
    logic          hs;
    logic          vs;
    logic          von;
    logic          hit;
    logic [IW-1:0] idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   pix_id = 0;
  logic take = 1'b0;

  // ---------------------------------------------------------------------------
  // Monitor: one output pixel per ce edge taken out of reset
  // ---------------------------------------------------------------------------
  always @(posedge clk) take <= reset & ce;

  always @(negedge clk) begin
    if (take) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL underflow: output pixel with no expectation, rgb=%h", rgb);
      end else begin
        mon_e = exp_q.pop_front();
        if ({rgb, hsync, vsync, video_on_out, hit_valid, hit_idx} !==
            {mon_e.rgb, mon_e.hs, mon_e.vs, mon_e.von, mon_e.hit, mon_e.idx}) begin
          n_bad++;
          $display("FAIL pix%0d: got rgb=%h hs=%b vs=%b von=%b hit=%b idx=%0d, want rgb=%h hs=%b vs=%b von=%b hit=%b idx=%0d",
                   mon_e.id, rgb, hsync, vsync, video_on_out, hit_valid, hit_idx,
                   mon_e.rgb, mon_e.hs, mon_e.vs, mon_e.von, mon_e.hit, mon_e.idx);
        end else begin
          $display("pix%0d ok: rgb=%h hit=%b idx=%0d hs=%b vs=%b von=%b",
                   mon_e.id, rgb, hit_valid, hit_idx, hsync, vsync, video_on_out);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end else begin
      $display("%s ok: %h", name, got);
    end
  endtask

  task automatic set_rgb(input int i, input logic [RW-1:0] c);
    layer_rgb[i*RW +: RW] = c;
  endtask

  task automatic set_mask(input int i, input logic [SW-1:0] m);
    layer_state_mask[i*SW +: SW] = m;
  endtask

  // Issue one pixel on the next clock edge with ce=1.
  task automatic pix(input logic von, input logic hs, input logic vs,
                     input logic [RW-1:0] er, input logic eh, input logic [IW-1:0] ei);
    exp_t e;
    video_on = von;
    hsync_in = hs;
    vsync_in = vs;
    ce       = 1'b1;
    e.id  = 16'(pix_id);
    e.rgb = er;
    e.hs  = hs;
    e.vs  = vs;
    e.von = von;
    e.hit = eh;
    e.idx = ei;
    pix_id++;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // ce=0 cycles with scrambled layer data; nothing may be captured.
  task automatic gap(input int n);
    logic [NL*RW-1:0] save_rgb;
    logic [NL-1:0]    save_on;
    save_rgb  = layer_rgb;
    save_on   = layer_on;
    ce        = 1'b0;
    layer_rgb = ~layer_rgb;
    layer_on  = ~layer_on;
    repeat (n) @(posedge clk);
    #1;
    layer_rgb = save_rgb;
    layer_on  = save_on;
  endtask

  task automatic do_reset(input int n, input logic ce_val, input string tag);
    exp_t idle;
    reset = 1'b0;
    ce    = ce_val;
    repeat (n) @(posedge clk);
    #1;
    chk({tag, "_rgb"}, 32'(rgb), 32'h0);
    chk({tag, "_ctl"}, 32'({hsync, vsync, video_on_out, hit_valid, hit_idx}), 32'b11_0_0_0000);
    chk({tag, "_blink"}, 32'(blink_phase), 32'h1);
    // The two output pixels after release come from the flushed pipeline.
    exp_q.delete();
    idle = '{id: 16'hFFFF, rgb: '0, hs: 1'b1, vs: 1'b1, von: 1'b0, hit: 1'b0, idx: '0};
    exp_q.push_back(idle);
    exp_q.push_back(idle);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    #1;
    do_reset(2, 1'b1, "rst");

    // Priority and latency, with ce gaps between changing pixels
    layer_on = 12'h006;
    set_rgb(1, 12'h0F0);
    set_rgb(2, 12'h00F);
    pix(1, 1, 1, 12'h0F0, 1, 1);
    pix(1, 1, 1, 12'h0F0, 1, 1);
    gap(3);
    pix(1, 1, 1, 12'h0F0, 1, 1);
    layer_on = 12'h004;
    pix(1, 1, 1, 12'h00F, 1, 2);
    gap(2);
    pix(1, 1, 1, 12'h00F, 1, 2);
    gap(1);
    layer_on = 12'h006;
    pix(1, 1, 1, 12'h0F0, 1, 1);

    // Colour-key transparency on layer 0
    layer_on = 12'h009;
    set_rgb(0, 12'hF0F);
    set_rgb(3, 12'h123);
    pix(1, 1, 1, 12'h123, 1, 3);
    pix(1, 1, 1, 12'h123, 1, 3);

    // State gating: layer 3 only allowed in state 001
    layer_on = 12'h008;
    set_mask(3, 3'b001);
    game_state = 3'b100;
    pix(1, 1, 1, 12'h555, 0, 0);

    // game_state all zeros: background only
    game_state = 3'b000;
    layer_on = 12'hFFF;
    pix(1, 1, 1, 12'h555, 0, 0);

    // All qualify: layer 0 wins; then layer 0 off -> layer 1
    game_state = 3'b010;
    set_mask(3, 3'b111);
    set_rgb(0, 12'h0A1);
    pix(1, 1, 1, 12'h0A1, 1, 0);
    layer_on = 12'hFFE;
    pix(1, 1, 1, 12'h0F0, 1, 1);

    // Key colour on layer 5 with key disabled is drawn; keyed layer 0 is not
    layer_on = 12'h021;
    set_rgb(0, 12'hF0F);
    set_rgb(5, 12'hF0F);
    pix(1, 1, 1, 12'hF0F, 1, 5);

    // Blanking and sync delay
    layer_on = 12'h001;
    set_rgb(0, 12'hFFF);
    pix(0, 0, 1, 12'h000, 0, 0);
    pix(0, 1, 0, 12'h000, 0, 0);
    pix(0, 0, 0, 12'h000, 0, 0);
    gap(2);
    pix(0, 1, 1, 12'h000, 0, 0);
    pix(1, 1, 1, 12'hFFF, 1, 0);

    // Fresh start for the blink test
    do_reset(2, 1'b0, "rst2");
    blink_mask = 12'h001;
    bg_rgb     = 12'h000;
    pix(1, 1, 1, 12'hFFF, 1, 0);
    pix(1, 1, 0, 12'hFFF, 1, 0);
    chk("blink_one_edge", 32'(blink_phase), 32'h1);
    pix(1, 1, 0, 12'hFFF, 1, 0);
    pix(1, 1, 0, 12'hFFF, 1, 0);
    pix(1, 1, 0, 12'hFFF, 1, 0);
    chk("blink_held_low", 32'(blink_phase), 32'h1);
    pix(1, 1, 1, 12'hFFF, 1, 0);
    pix(1, 1, 0, 12'hFFF, 1, 0);
    chk("blink_off", 32'(blink_phase), 32'h0);
    pix(1, 1, 0, 12'h000, 0, 0);
    pix(1, 1, 1, 12'h000, 0, 0);
    pix(1, 1, 0, 12'h000, 0, 0);
    chk("blink_off_hold", 32'(blink_phase), 32'h0);
    pix(1, 1, 1, 12'h000, 0, 0);
    pix(1, 1, 0, 12'h000, 0, 0);
    chk("blink_on", 32'(blink_phase), 32'h1);
    pix(1, 1, 0, 12'hFFF, 1, 0);

    // Back to off phase with the counter left at 1, then reset mid-stream
    pix(1, 1, 1, 12'hFFF, 1, 0);
    pix(1, 1, 0, 12'hFFF, 1, 0);
    pix(1, 1, 1, 12'hFFF, 1, 0);
    pix(1, 1, 0, 12'hFFF, 1, 0);
    pix(1, 1, 0, 12'h000, 0, 0);
    pix(1, 1, 1, 12'h000, 0, 0);
    pix(1, 1, 0, 12'h000, 0, 0);
    pix(1, 1, 0, 12'h000, 0, 0);
    chk("blink_off2", 32'(blink_phase), 32'h0);
    do_reset(2, 1'b0, "rst_mid");

    // Counter restarted: one edge must not toggle, the second must
    pix(1, 1, 1, 12'hFFF, 1, 0);
    pix(1, 1, 0, 12'hFFF, 1, 0);
    chk("cnt_restart", 32'(blink_phase), 32'h1);
    pix(1, 1, 1, 12'hFFF, 1, 0);
    pix(1, 1, 0, 12'hFFF, 1, 0);
    chk("blink_off3", 32'(blink_phase), 32'h0);
    pix(1, 1, 1, 12'h000, 0, 0);
    pix(1, 1, 1, 12'h000, 0, 0);
    pix(1, 1, 1, 12'h000, 0, 0);
    pix(1, 1, 1, 12'h000, 0, 0);
    ce = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
- Parametrised, pipelined successor to the fixed priority RGB mux in the display top level.
- Takes NUM_LAYERS sprite/overlay layers, each with an on flag and RGB data, plus a background colour. For every pixel it selects the highest-priority visible layer.
- Visibility is gated by a per-layer game-state mask, per-layer colour-key transparency and a frame-based blink effect.
- The VGA sync and blanking signals are delayed to stay aligned with the selected pixel. Output goes directly to the VGA DAC.

Parameters:
NUM_LAYERS, 12, number of input layers; index 0 = highest priority
RGB_W, 12, bits per pixel colour
STATE_W, 3, width of one-hot game_state
KEY_COLOR, 12'hF0F, transparent colour key
KEY_EN, {NUM_LAYERS{1'b1}}, per-layer colour-key enable bitmask
BLINK_FRAMES, 16, frames per blink half-period (>=1)
IDX_W, 4, width of hit_idx (>= clog2(NUM_LAYERS))

Ports:
clk  in  1  pixel-domain clock
reset  in  1  synchronous, active-low reset
ce  in  1  pipeline advance enable (pixel tick); pipeline holds when 0
video_on  in  1  active-video flag from the sync generator
hsync_in  in  1  hsync from the sync generator (active low)
vsync_in  in  1  vsync from the sync generator (active low)
game_state  in  STATE_W  one-hot game state
layer_on  in  NUM_LAYERS  per-layer pixel-on flags
layer_rgb  in  NUM_LAYERS*RGB_W  layer i colour in bits [i*RGB_W +: RGB_W]
layer_state_mask  in  NUM_LAYERS*STATE_W  states in which layer i may show
blink_mask  in  NUM_LAYERS  layers subject to blinking
bg_rgb  in  RGB_W  background colour when no layer qualifies
rgb  out  RGB_W  registered pixel to the DAC
hsync  out  1  hsync delayed to match rgb
vsync  out  1  vsync delayed to match rgb
video_on_out  out  1  video_on delayed to match rgb
hit_valid  out  1  a layer won the current output pixel
hit_idx  out  IDX_W  index of the winning layer (0 when hit_valid=0)
blink_phase  out  1  current blink phase; 1 = blinking layers visible

Behaviour:
- Reset (reset==0 at posedge clk) sets the following, regardless of ce:
  - rgb=0, hit_valid=0, hit_idx=0, video_on_out=0, hsync=1, vsync=1.
  - All internal pipeline registers cleared to the same idle values.
  - Frame counter=0, blink_phase=1, stored previous vsync=1.
- Pipeline: 3 stages, all registers update only on posedge clk with ce=1. With ce=0 every register holds. Latency is exactly 3 ce-cycles from inputs to rgb/hsync/vsync/video_on_out.
- S1, qualification (registered):
  - q[i] = layer_on[i] & |(layer_state_mask[i] & game_state) & ~(KEY_EN[i] & layer_rgb[i]==KEY_COLOR) & (~blink_mask[i] | blink_phase).
  - Register q, all layer_rgb, bg_rgb, video_on, hsync_in, vsync_in.
- S2, priority select (registered): lowest index with q set wins. Register the winner's rgb (or bg_rgb if none), hit flag and index, plus the delayed syncs and video_on.
- S3, output register:
  - rgb = S2 colour if S2 video_on=1, else 0.
  - hit_valid = hit & video_on. hit_idx = index if hit_valid, else 0.
  - Syncs and video_on_out copied from S2.
- Blink engine:
  - On a ce cycle where vsync_in goes 1->0 relative to its stored previous value, the frame counter increments.
  - When the counter reaches BLINK_FRAMES-1 and another falling edge arrives, the counter returns to 0 and blink_phase toggles.
  - The previous-vsync register updates only on ce.
  - blink_phase is sampled in S1, so a toggle affects pixels entering S1 on the following ce cycle.
- Boundary cases:
  - All layers qualify: layer 0 wins.
  - No layer qualifies: bg_rgb.
  - A layer whose colour equals KEY_COLOR with KEY_EN=0 is drawn normally.
  - game_state of all zeros: no layer shows, background only.
  - video_on=0: rgb=0 even if layers are on.
- Reset asserted mid-frame flushes the pipeline. The output is idle for the following 3 ce-cycles after release, and blink restarts in the visible phase.

Test Plan:
- Reset with reset=0 for 2 clk, then inputs constant with ce=1 -> rgb=0, hsync=vsync=1, hit_valid=0, blink_phase=1 until the 3rd ce-cycle after release.
- Priority and latency: layer_on=12'b0000_0000_0110, layer 1 = 12'h0F0, layer 2 = 12'h00F, all masks 3'b111, game_state=3'b010, video_on=1 -> rgb=12'h0F0 and hit_idx=1 exactly 3 ce-cycles later. Insert ce=0 gaps and confirm the latency counts only ce cycles.
- Transparency and state gating:
  - layer 0 on with 12'hF0F and KEY_EN bit 0 = 1, layer 3 = 12'h123 -> rgb=12'h123.
  - Layer 3 mask 3'b001 with game_state=3'b100 -> rgb=bg_rgb, hit_valid=0.
- Blanking: video_on=0 with layer 0 on at 12'hFFF -> rgb=0, hit_valid=0, video_on_out=0 after 3 cycles. hsync/vsync patterns are delayed exactly 3 ce-cycles.
- Blink, BLINK_FRAMES=2: layer 0 in blink_mask at 12'hFFF, bg 12'h000.
  - Drive 2 vsync falling edges -> blink_phase=0 and rgb=12'h000 for that pixel.
  - 2 more edges -> phase=1 and rgb=12'hFFF.
  - A vsync low held for many ce counts only once.
- Mid-operation reset: assert reset during the blink-off phase with the pipeline full -> outputs idle, blink_phase=1, frame counter restarts (2 edges needed to toggle again).
